// File: rtl/bit_stream_serializer.sv
// Parallel-to-serial front end: small word FIFO feeding a bit shifter.
// Words leave back to back, one bit per clock, while the FIFO has data.
module bit_stream_serializer #(
    parameter int WIDTH     = 4,
    parameter int DEPTH     = 2,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] word_in,
    input  logic             word_valid,
    output logic             word_ready,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             frame_start,
    output logic             busy,
    output logic [31:0]      words_sent
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int BW = $clog2(WIDTH);

    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [BW-1:0]    bitcnt_q;
    logic [31:0]      words_sent_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_q;
    logic [AW-1:0]    wr_q;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] head;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + AW'(1);
    endfunction

    assign word_ready = ~rst & (cnt_q < FULL_CNT);
    assign push       = word_valid & word_ready;
    assign head       = mem_q[rd_q];

    // Pop when the shifter can take a word: idle, or retiring its last bit.
    always_comb begin
        pop   = (cnt_q != '0) &&
                ((state_q == S_IDLE) || (bitcnt_q == LAST_BIT));
        cnt_d = cnt_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // FIFO storage, pointers and the shifter FSM share one clocked block.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            shreg_q      <= '0;
            bitcnt_q     <= '0;
            words_sent_q <= '0;
            rd_q         <= '0;
            wr_q         <= '0;
            cnt_q        <= '0;
        end else begin
            if (push) begin
                mem_q[wr_q] <= word_in;
                wr_q        <= ptr_inc(wr_q);
            end
            if (pop) begin
                rd_q <= ptr_inc(rd_q);
            end
            cnt_q <= cnt_d;
            unique case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        shreg_q  <= head;
                        bitcnt_q <= '0;
                        state_q  <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (bitcnt_q != LAST_BIT) begin
                        shreg_q  <= MSB_FIRST ? (shreg_q << 1)
                                              : (shreg_q >> 1);
                        bitcnt_q <= bitcnt_q + BW'(1);
                    end else begin
                        words_sent_q <= words_sent_q + 32'd1;
                        bitcnt_q     <= '0;
                        if (pop) begin
                            shreg_q <= head;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Serial outputs decode registered state only.
    always_comb begin
        bit_valid   = (state_q == S_SHIFT);
        frame_start = bit_valid && (bitcnt_q == '0);
        bit_out     = IDLE_BIT;
        if (bit_valid) begin
            bit_out = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
        end
        busy       = (cnt_q != '0) || bit_valid;
        words_sent = words_sent_q;
    end

endmodule

// File: tb/tb_bit_stream_serializer.sv
// Directed bench for bit_stream_serializer: MSB-first and LSB-first
// instances share one stimulus stream.
module tb_bit_stream_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] wi;
    logic       wv;

    logic        wr0, bo0, bv0, fs0, busy0;
    logic [31:0] ws0;
    logic        wr1, bo1, bv1, fs1, busy1;
    logic [31:0] ws1;

    int checks = 0;
    int errors = 0;

    logic [31:0] col;
    int          ncol;
    int          nfr;
    logic [7:0]  pat;
    logic [31:0] ws_exp;

    always #5 clk = ~clk;

    bit_stream_serializer #(.WIDTH(4), .DEPTH(2), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut0 (
        .clk(clk), .rst(rst), .word_in(wi), .word_valid(wv),
        .word_ready(wr0), .bit_out(bo0), .bit_valid(bv0),
        .frame_start(fs0), .busy(busy0), .words_sent(ws0)
    );

    bit_stream_serializer #(.WIDTH(4), .DEPTH(2), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut1 (
        .clk(clk), .rst(rst), .word_in(wi), .word_valid(wv),
        .word_ready(wr1), .bit_out(bo1), .bit_valid(bv1),
        .frame_start(fs1), .busy(busy1), .words_sent(ws1)
    );

    always @(posedge clk) begin
        if (!rst && bv0) begin
            col  = {col[30:0], bo0};
            ncol = ncol + 1;
            if (fs0) nfr = nfr + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] w);
        wi = w;
        wv = 1'b1;
        for (int k = 0; k < 50 && !wr0; k++) tick();
        chk("push_ready", {31'd0, wr0}, 32'd1);
        tick();
        wv = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && (busy0 || bv0); k++) tick();
        chk("drain_busy", {31'd0, busy0}, 32'd0);
    endtask

    initial begin
        rst  = 1'b1;
        wi   = '0;
        wv   = 1'b0;
        col  = '0;
        ncol = 0;
        nfr  = 0;
        tick();
        tick();
        chk("rst_bv", {31'd0, bv0}, 32'd0);
        chk("rst_ready", {31'd0, wr0}, 32'd0);
        chk("rst_busy", {31'd0, busy0}, 32'd0);
        chk("rst_ws", ws0, 32'd0);
        chk("rst_bout", {31'd0, bo0}, 32'd0);
        chk("rst_fs", {31'd0, fs0}, 32'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", {31'd0, wr0}, 32'd1);

        // single word 0xA, MSB first
        push(4'hA);
        chk("t1_latency_bv", {31'd0, bv0}, 32'd0);
        chk("t1_busy", {31'd0, busy0}, 32'd1);
        pat = 8'h0A;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t1_bv", {31'd0, bv0}, 32'd1);
            chk("t1_bit", {31'd0, bo0}, {31'd0, pat[3-i]});
            chk("t1_fs", {31'd0, fs0}, (i == 0) ? 32'd1 : 32'd0);
        end
        tick();
        chk("t1_bv_end", {31'd0, bv0}, 32'd0);
        chk("t1_ws", ws0, 32'd1);
        chk("t1_busy_end", {31'd0, busy0}, 32'd0);

        // 0xA then 0x5 back to back
        push(4'hA);
        push(4'h5);
        pat = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            chk("t2_bv", {31'd0, bv0}, 32'd1);
            chk("t2_bit", {31'd0, bo0}, {31'd0, pat[7-i]});
            chk("t2_fs", {31'd0, fs0}, (i == 0 || i == 4) ? 32'd1 : 32'd0);
            tick();
        end
        chk("t2_bv_end", {31'd0, bv0}, 32'd0);
        chk("t2_ws", ws0, 32'd3);

        // backpressure: fill FIFO while shifting, no loss or duplication
        col  = '0;
        ncol = 0;
        nfr  = 0;
        push(4'hF);
        push(4'h3);
        push(4'hC);
        chk("t3_full_ready", {31'd0, wr0}, 32'd0);
        tick();
        chk("t3_still_full", {31'd0, wr0}, 32'd0);
        push(4'h9);
        drain();
        chk("t3_stream", col & 32'h0000_FFFF, 32'h0000_F3C9);
        chk("t3_nbits", ncol, 32'd16);
        chk("t3_frames", nfr, 32'd4);
        chk("t3_ws", ws0, 32'd7);

        // LSB-first instance on 4'b0101
        push(4'b0101);
        tick();
        pat = 8'h05;
        for (int i = 0; i < 4; i++) begin
            chk("t4_lsb_bit", {31'd0, bo1}, {31'd0, pat[i]});
            chk("t4_msb_bit", {31'd0, bo0}, {31'd0, pat[3-i]});
            chk("t4_lsb_bv", {31'd0, bv1}, 32'd1);
            tick();
        end
        chk("t4_ws_lsb", ws1, 32'd8);
        chk("t4_ws_msb", ws0, 32'd8);

        // reset mid-word with one word queued
        push(4'hA);
        push(4'h5);
        tick();
        chk("t5_bv_pre", {31'd0, bv0}, 32'd1);
        chk("t5_bit_pre", {31'd0, bo0}, 32'd0);
        rst = 1'b1;
        tick();
        chk("t5_bv_rst", {31'd0, bv0}, 32'd0);
        chk("t5_ws_rst", ws0, 32'd0);
        chk("t5_busy_rst", {31'd0, busy0}, 32'd0);
        chk("t5_ready_rst", {31'd0, wr0}, 32'd0);
        rst = 1'b0;
        #1;
        chk("t5_ready_after", {31'd0, wr0}, 32'd1);
        tick();
        chk("t5_bv_after", {31'd0, bv0}, 32'd0);
        chk("t5_busy_after", {31'd0, busy0}, 32'd0);

        // idle after traffic
        push(4'h6);
        drain();
        ws_exp = 32'd1;
        chk("t6_ws", ws0, ws_exp);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t6_bv", {31'd0, bv0}, 32'd0);
            chk("t6_bout", {31'd0, bo0}, 32'd0);
            chk("t6_ws_stable", ws0, ws_exp);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
